ysyx_22040088_lsu: RTL and testbench
====================================

Name: ysyx_22040088_lsu

Overview:
Multi-cycle load/store unit directly downstream of the EXU. It consumes the ALU-computed address, the store data (rs2) and the funct3 size code, and drives a valid/ready request/response bus to data memory. It returns sign- or zero-extended load data, or a store acknowledge, to register writeback. It replaces the combinational memory path so that memory may take arbitrary latency.

Parameters:
TIMEOUT, 255, max cycles spent in WAIT for a response before aborting with err; 0 disables the timeout.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  EXU presents a memory op
in_ready  output  1  LSU can accept (high only in IDLE)
in_load  input  1  op is a load
in_store  input  1  op is a store
in_funct3  input  3  RV64 size/sign code
in_addr  input  64  byte address (alu_result)
in_wdata  input  64  store data (rs2)
mem_req_valid  output  1  request valid
mem_req_ready  input  1  memory accepts request
mem_req_wen  output  1  1 = write
mem_req_addr  output  64  in_addr with bits [2:0] cleared
mem_req_wdata  output  64  lane-shifted store data
mem_req_wmask  output  8  byte enables
mem_resp_valid  input  1  response/ack valid (single-cycle pulse)
mem_resp_rdata  input  64  aligned doubleword read data
out_valid  output  1  result available
out_ready  input  1  writeback accepts result
out_rdata  output  64  formatted load data; 0 for stores and errors
out_err  output  1  misaligned, illegal funct3, both load and store set, or timeout

Behaviour:
- Reset (async, rst=1): state IDLE. in_ready=1; all other outputs 0; timeout counter 0. Reset asserted in any state aborts the op with no further bus activity. An outstanding memory response arriving after reset is ignored.
- States: IDLE, REQ, WAIT, DONE.
- IDLE: in_ready=1. On in_valid, all inputs are latched.
  - Error case: any of misaligned, funct3=111, or in_load&in_store. Next state DONE with err=1, rdata=0, and no bus request.
  - Neither in_load nor in_store: next state DONE with err=0, rdata=0.
  - Otherwise: next state REQ.
- Misalignment: halfword needs addr[0]=0; word needs addr[1:0]=0; doubleword needs addr[2:0]=0.
- REQ: mem_req_valid=1. mem_req_addr, wen, wdata and wmask come from the latched values and stay stable until mem_req_ready. On the handshake cycle, go to WAIT and clear the counter.
- WAIT: mem_req_valid=0. Each cycle without mem_resp_valid increments the counter.
  - mem_resp_valid: capture and format the data, go to DONE with err=0.
  - Timeout: if TIMEOUT≠0 and the counter reaches TIMEOUT-1 without a response, go to DONE with err=1 and rdata=0.
  - A response on the same cycle as the timeout wins: the data is captured with err=0.
- DONE: out_valid=1, out_rdata and out_err held until out_ready; then go to IDLE. in_ready is 0 until the cycle after the out handshake.
- Lane and mask generation (lane = addr[2:0]):
  - wmask = (1, 3, F or FF for byte/half/word/double) << lane.
  - wdata = in_wdata << (8*lane).
  - Loads drive wmask=0 and wen=0.
- Load formatting: shifted = rdata >> (8*lane), then by funct3:
  - 000: sign-extend bits [7:0]
  - 001: sign-extend bits [15:0]
  - 010: sign-extend bits [31:0]
  - 011: full 64 bits
  - 100: zero-extend bits [7:0]
  - 101: zero-extend bits [15:0]
  - 110: zero-extend bits [31:0]
- Stores: out_rdata=0. The ack still requires mem_resp_valid.
- Minimum latency, zero-wait memory with out_ready=1 (accept at cycle T):
  - T+1: request handshake.
  - T+2: response.
  - T+3: out_valid.
  - T+4: next accept.
- Error ops: out_valid at T+1.
- mem_resp_valid outside WAIT is ignored. Inputs changing outside IDLE are ignored.

Test Plan:
- Load byte sign: ld funct3=000, addr=0x80000003, rdata=0x0000_0000_8000_0000 -> out_rdata=0xFFFF_FFFF_FFFF_FF80, err=0, req_addr=0x80000000, out_valid 3 cycles after accept with a zero-wait memory.
- Load word unsigned: funct3=110, addr=0x80000004, rdata=0xDEADBEEF_12345678 -> out_rdata=0x0000_0000_DEAD_BEEF.
- Store half: funct3=001, addr=0x80000006, wdata=0x1234 -> wmask=0xC0, req_wdata=0x1234_0000_0000_0000, wen=1, out_rdata=0 after ack.
- Misaligned word: funct3=010, addr=0x80000002 -> no mem_req_valid ever, out_valid next cycle with err=1, rdata=0.
- Backpressure/timeout: mem_req_ready low 5 cycles, then high; request held stable throughout. With TIMEOUT=4 and no response -> err=1 four cycles after entering WAIT. out_ready low 3 cycles -> outputs held.
- Reset mid-WAIT: assert rst -> immediate IDLE, in_ready=1, out_valid=0. A late mem_resp_valid is ignored and the next op completes correctly.

Source files
------------

// File: rtl/ysyx_22040088_lsu.sv
// Multi-cycle load/store unit: latches one EXU memory op, runs a valid/ready
// request/response exchange with data memory and returns formatted load data.
module ysyx_22040088_lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [2:0]  in_funct3,
  input  logic [63:0] in_addr,
  input  logic [63:0] in_wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_wen,
  output logic [63:0] mem_req_addr,
  output logic [63:0] mem_req_wdata,
  output logic [7:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_rdata,
  output logic        out_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [31:0] TO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  state_t      r_state;
  logic [2:0]  r_funct3;
  logic [2:0]  r_lane;
  logic        r_store;
  logic [31:0] r_cnt;
  logic        r_in_ready;
  logic        r_req_valid;
  logic        r_req_wen;
  logic [63:0] r_req_addr;
  logic [63:0] r_req_wdata;
  logic [7:0]  r_req_wmask;
  logic        r_out_valid;
  logic [63:0] r_out_rdata;
  logic        r_out_err;

  logic        w_misaligned;
  logic        w_illegal;
  logic [7:0]  w_size_mask;
  logic [7:0]  w_wmask;
  logic [63:0] w_wdata;
  logic [63:0] w_shifted;
  logic [63:0] w_load_data;
  logic        w_timeout;

  always_comb begin
    w_misaligned = 1'b0;
    w_size_mask  = 8'h01;
    case (in_funct3[1:0])
      2'b00: begin
        w_misaligned = 1'b0;
        w_size_mask  = 8'h01;
      end
      2'b01: begin
        w_misaligned = in_addr[0];
        w_size_mask  = 8'h03;
      end
      2'b10: begin
        w_misaligned = |in_addr[1:0];
        w_size_mask  = 8'h0F;
      end
      default: begin
        w_misaligned = |in_addr[2:0];
        w_size_mask  = 8'hFF;
      end
    endcase
  end

  assign w_illegal = w_misaligned | (in_funct3 == 3'b111) | (in_load & in_store);
  assign w_wmask   = w_size_mask << in_addr[2:0];
  assign w_wdata   = in_wdata << {in_addr[2:0], 3'b000};
  assign w_shifted = mem_resp_rdata >> {r_lane, 3'b000};
  assign w_timeout = TO_EN && (r_cnt == TO_LAST);

  always_comb begin
    w_load_data = w_shifted;
    case (r_funct3)
      3'b000:  w_load_data = {{56{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_load_data = {{48{w_shifted[15]}}, w_shifted[15:0]};
      3'b010:  w_load_data = {{32{w_shifted[31]}}, w_shifted[31:0]};
      3'b100:  w_load_data = {56'd0, w_shifted[7:0]};
      3'b101:  w_load_data = {48'd0, w_shifted[15:0]};
      3'b110:  w_load_data = {32'd0, w_shifted[31:0]};
      default: w_load_data = w_shifted;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_funct3    <= 3'd0;
      r_lane      <= 3'd0;
      r_store     <= 1'b0;
      r_cnt       <= 32'd0;
      r_in_ready  <= 1'b1;
      r_req_valid <= 1'b0;
      r_req_wen   <= 1'b0;
      r_req_addr  <= 64'd0;
      r_req_wdata <= 64'd0;
      r_req_wmask <= 8'd0;
      r_out_valid <= 1'b0;
      r_out_rdata <= 64'd0;
      r_out_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_funct3   <= in_funct3;
            r_lane     <= in_addr[2:0];
            r_store    <= in_store;
            r_in_ready <= 1'b0;
            if (w_illegal || !(in_load || in_store)) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_out_err   <= w_illegal;
              r_out_rdata <= 64'd0;
            end else begin
              r_state     <= S_REQ;
              r_req_valid <= 1'b1;
              r_req_wen   <= in_store;
              r_req_addr  <= {in_addr[63:3], 3'b000};
              r_req_wdata <= in_store ? w_wdata : 64'd0;
              r_req_wmask <= in_store ? w_wmask : 8'd0;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            r_state     <= S_WAIT;
            r_req_valid <= 1'b0;
            r_cnt       <= 32'd0;
          end
        end
        S_WAIT: begin
          // a response landing on the timeout cycle still counts as success
          if (mem_resp_valid) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_out_err   <= 1'b0;
            r_out_rdata <= r_store ? 64'd0 : w_load_data;
          end else if (w_timeout) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_out_err   <= 1'b1;
            r_out_rdata <= 64'd0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
            r_out_rdata <= 64'd0;
            r_in_ready  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign mem_req_valid = r_req_valid;
  assign mem_req_wen   = r_req_wen;
  assign mem_req_addr  = r_req_addr;
  assign mem_req_wdata = r_req_wdata;
  assign mem_req_wmask = r_req_wmask;
  assign out_valid     = r_out_valid;
  assign out_rdata     = r_out_rdata;
  assign out_err       = r_out_err;

endmodule

// File: tb/tb_ysyx_22040088_lsu.sv
// Directed bench for ysyx_22040088_lsu: a scoreboard queue holds the expected
// result of each op and is drained when the LSU presents its output.
module tb_ysyx_22040088_lsu;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_load;
  logic        in_store;
  logic [2:0]  in_funct3;
  logic [63:0] in_addr;
  logic [63:0] in_wdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wen;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_rdata;
  logic        out_err;

  int   total;
  int   bad;
  exp_t sb[$];

  ysyx_22040088_lsu #(.TIMEOUT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_load        (in_load),
    .in_store       (in_store),
    .in_funct3      (in_funct3),
    .in_addr        (in_addr),
    .in_wdata       (in_wdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_wen    (mem_req_wen),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_rdata      (out_rdata),
    .out_err        (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the LSU idle; returns at a negedge with it idle again.
  task automatic run_op(input string tag, input bit ld, input bit st, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                        input int req_stall, input int resp_delay, input int out_stall,
                        input bit exp_bus, input logic [7:0] exp_wmask,
                        input logic [63:0] exp_wdata, input logic [63:0] exp_rdata,
                        input bit exp_err, input int exp_lat);
    exp_t e;
    int   lat;
    int   n;
    logic [63:0] exp_addr;
    exp_addr = addr & ~64'h7;
    check({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    in_load   = ld;
    in_store  = st;
    in_funct3 = f3;
    in_addr   = addr;
    in_wdata  = wd;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb.push_back(e);
    @(negedge clk);
    lat = 1;
    in_valid  = 1'b0;
    in_load   = 1'($urandom_range(0, 1));
    in_store  = 1'($urandom_range(0, 1));
    in_funct3 = 3'($urandom);
    in_addr   = {$urandom, $urandom};
    in_wdata  = {$urandom, $urandom};
    check({tag, ".in_ready_busy"}, 64'(in_ready), 64'd0);
    if (exp_bus) begin
      for (int i = 0; i < req_stall; i++) begin
        check({tag, ".hold_valid"}, 64'(mem_req_valid), 64'd1);
        check({tag, ".hold_addr"}, mem_req_addr, exp_addr);
        check({tag, ".hold_wdata"}, mem_req_wdata, exp_wdata);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = {$urandom, $urandom};
        @(negedge clk);
        lat++;
      end
      mem_resp_valid = 1'b0;
      check({tag, ".req_valid"}, 64'(mem_req_valid), 64'd1);
      check({tag, ".req_addr"}, mem_req_addr, exp_addr);
      check({tag, ".req_wen"}, 64'(mem_req_wen), 64'(st));
      check({tag, ".req_wdata"}, mem_req_wdata, exp_wdata);
      check({tag, ".req_wmask"}, 64'(mem_req_wmask), 64'(exp_wmask));
      mem_req_ready = 1'b1;
      @(negedge clk);
      lat++;
      mem_req_ready = 1'b0;
      check({tag, ".req_drop"}, 64'(mem_req_valid), 64'd0);
      if (resp_delay >= 0) begin
        for (int i = 0; i < resp_delay; i++) begin
          check({tag, ".early_out"}, 64'(out_valid), 64'd0);
          @(negedge clk);
          lat++;
        end
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rd;
        @(negedge clk);
        lat++;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = {$urandom, $urandom};
      end
    end else begin
      check({tag, ".no_req"}, 64'(mem_req_valid), 64'd0);
    end
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      lat++;
      n++;
    end
    check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    if (exp_lat >= 0) check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".sb_depth"}, 64'(sb.size()), 64'd1);
    if (sb.size() > 0) e = sb.pop_front();
    for (int i = 0; i < out_stall; i++) begin
      check({tag, ".held_valid"}, 64'(out_valid), 64'd1);
      check({tag, ".held_rdata"}, out_rdata, e.rdata);
      check({tag, ".held_err"}, 64'(out_err), 64'(e.err));
      check({tag, ".held_in_ready"}, 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    check({tag, ".rdata"}, out_rdata, e.rdata);
    check({tag, ".err"}, 64'(out_err), 64'(e.err));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".out_drop"}, 64'(out_valid), 64'd0);
    check({tag, ".in_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    rst            = 1'b1;
    in_valid       = 1'b0;
    in_load        = 1'b0;
    in_store       = 1'b0;
    in_funct3      = 3'd0;
    in_addr        = 64'd0;
    in_wdata       = 64'd0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 64'd0;
    out_ready      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.req_valid", 64'(mem_req_valid), 64'd0);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.out_err", 64'(out_err), 64'd0);
    check("rst.out_rdata", out_rdata, 64'd0);
    check("rst.req_addr", mem_req_addr, 64'd0);
    check("rst.req_wmask", 64'(mem_req_wmask), 64'd0);
    check("rst.req_wen", 64'(mem_req_wen), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // tag, ld, st, f3, addr, wdata, rdata, req_stall, resp_delay, out_stall,
    // bus, wmask, req_wdata, out_rdata, err, latency
    run_op("lb_sign", 1, 0, 3'b000, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 0, 0, 0,
           1, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 0, 3);
    run_op("lwu", 1, 0, 3'b110, 64'h8000_0004, 64'h0, 64'hDEAD_BEEF_1234_5678, 0, 0, 0,
           1, 8'h00, 64'h0, 64'h0000_0000_DEAD_BEEF, 0, 3);
    run_op("sh", 0, 1, 3'b001, 64'h8000_0006, 64'h0000_0000_0000_1234, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0,
           1, 8'hC0, 64'h1234_0000_0000_0000, 64'h0, 0, 3);
    run_op("mis_lw", 1, 0, 3'b010, 64'h8000_0002, 64'h0, 64'h0, 0, 0, 0,
           0, 8'h00, 64'h0, 64'h0, 1, 1);
    run_op("ld_stall", 1, 0, 3'b011, 64'h8000_0008, 64'h0, 64'h0123_4567_89AB_CDEF, 5, 2, 3,
           1, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 10);
    run_op("lw_timeout", 1, 0, 3'b010, 64'h8000_0010, 64'h0, 64'h0, 0, -1, 0,
           1, 8'h00, 64'h0, 64'h0, 1, 6);
    run_op("lh_resp_at_timeout", 1, 0, 3'b001, 64'h8000_0012, 64'h0, 64'h0000_0000_8001_0000, 0, 3, 0,
           1, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 0, 6);
    run_op("lbu", 1, 0, 3'b100, 64'h8000_0007, 64'h0, 64'hAB00_0000_0000_0000, 0, 1, 0,
           1, 8'h00, 64'h0, 64'h0000_0000_0000_00AB, 0, 4);
    run_op("lb_top", 1, 0, 3'b000, 64'h8000_0007, 64'h0, 64'hAB00_0000_0000_0000, 0, 0, 0,
           1, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FFAB, 0, 3);
    run_op("lhu", 1, 0, 3'b101, 64'h8000_000E, 64'h0, 64'hBEEF_0000_0000_0000, 0, 0, 0,
           1, 8'h00, 64'h0, 64'h0000_0000_0000_BEEF, 0, 3);
    run_op("lw_sign", 1, 0, 3'b010, 64'h8000_0004, 64'h0, 64'h8000_0000_0000_0000, 0, 0, 0,
           1, 8'h00, 64'h0, 64'hFFFF_FFFF_8000_0000, 0, 3);
    run_op("sd", 0, 1, 3'b011, 64'h8000_0000, 64'h1122_3344_5566_7788, 64'h5555_AAAA_5555_AAAA, 0, 0, 0,
           1, 8'hFF, 64'h1122_3344_5566_7788, 64'h0, 0, 3);
    run_op("sb", 0, 1, 3'b000, 64'h8000_0005, 64'hFFFF_FFFF_FFFF_FFA5, 64'h1234_1234_1234_1234, 2, 0, 1,
           1, 8'h20, 64'hFFFF_A500_0000_0000, 64'h0, 0, 5);
    run_op("f3_illegal", 1, 0, 3'b111, 64'h8000_0000, 64'h0, 64'h0, 0, 0, 0,
           0, 8'h00, 64'h0, 64'h0, 1, 1);
    run_op("ld_and_st", 1, 1, 3'b011, 64'h8000_0000, 64'h0, 64'h0, 0, 0, 0,
           0, 8'h00, 64'h0, 64'h0, 1, 1);
    run_op("mis_ld", 1, 0, 3'b011, 64'h8000_0004, 64'h0, 64'h0, 0, 0, 2,
           0, 8'h00, 64'h0, 64'h0, 1, 1);
    run_op("no_op", 0, 0, 3'b000, 64'h8000_0001, 64'h0, 64'h0, 0, 0, 0,
           0, 8'h00, 64'h0, 64'h0, 0, 1);

    // abort an op in WAIT, then show a stale response has no effect
    in_valid  = 1'b1;
    in_load   = 1'b1;
    in_store  = 1'b0;
    in_funct3 = 3'b011;
    in_addr   = 64'h8000_0020;
    @(negedge clk);
    in_valid = 1'b0;
    check("rstwait.req_valid", 64'(mem_req_valid), 64'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstwait.in_ready", 64'(in_ready), 64'd1);
    check("rstwait.out_valid", 64'(out_valid), 64'd0);
    check("rstwait.req_valid0", 64'(mem_req_valid), 64'd0);
    @(negedge clk);
    rst            = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'hFEED_FACE_FEED_FACE;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    check("late_resp.out_valid", 64'(out_valid), 64'd0);
    check("late_resp.in_ready", 64'(in_ready), 64'd1);
    check("late_resp.req_valid", 64'(mem_req_valid), 64'd0);

    run_op("sw_after_rst", 0, 1, 3'b010, 64'h8000_000C, 64'h0000_0000_CAFE_BABE, 64'h0, 0, 0, 0,
           1, 8'hF0, 64'hCAFE_BABE_0000_0000, 64'h0, 0, 3);
    run_op("ld_after_rst", 1, 0, 3'b011, 64'h8000_0020, 64'h0, 64'h0F0E_0D0C_0B0A_0908, 0, 0, 0,
           1, 8'h00, 64'h0, 64'h0F0E_0D0C_0B0A_0908, 0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
